// File: rtl/adder_tree_pipe_if.sv
// Stream bundle for adder_tree_pipe: product beats in, reduced/clamped results out.
// The slave modport is the adder tree; the master modport is whoever feeds and drains it.
interface adder_tree_pipe_if #(
  parameter int NUM_TERMS    = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_W      = 4
);
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LEVELS = $clog2(NUM_TERMS);
  localparam int SUM_W  = PROD_W + LEVELS;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_TERMS*PROD_W-1:0] in_data;
  logic                        in_signed;
  logic [SHIFT_W-1:0]          in_shift;
  logic                        in_relu;
  logic                        out_valid;
  logic                        out_ready;
  logic [SUM_W-1:0]            out_sum;
  logic [OUT_WIDTH-1:0]        out_data;
  logic                        out_sat;

  modport slave (
    input  in_valid, in_data, in_signed, in_shift, in_relu, out_ready,
    output in_ready, out_valid, out_sum, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, in_signed, in_shift, in_relu, out_ready,
    input  in_ready, out_valid, out_sum, out_data, out_sat
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Fully pipelined NUM_TERMS-way product reducer: pairwise add tree, rounding right
// shift, optional ReLU, clamp to OUT_WIDTH and a saturating count of clamped results.
module adder_tree_pipe #(
  parameter int NUM_TERMS    = 9,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_tree_pipe_if.slave        bus,
  input  logic                    sat_clear,
  output logic [15:0]             sat_count
);
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LEVELS = $clog2(NUM_TERMS);
  localparam int SUM_W  = PROD_W + LEVELS;
  localparam int EXT_W  = SUM_W + 1;
  localparam int VEC_W  = NUM_TERMS * SUM_W;

  localparam logic signed [EXT_W-1:0] S_MAX = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] S_MIN = {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic        [EXT_W-1:0] U_MAX = {{(EXT_W-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  function automatic logic [SUM_W-1:0] extend_term(input logic [PROD_W-1:0] p, input logic sgn);
    logic [SUM_W-1:0] r;
    if (sgn) begin
      r = SUM_W'($signed(p));
    end else begin
      r = SUM_W'(p);
    end
    return r;
  endfunction

  function automatic int terms_at(input int l);
    return (NUM_TERMS + (1 << l) - 1) >> l;
  endfunction

  // Terms are kept pre-extended to SUM_W, so a pass-through term needs no further widening.
  function automatic logic [VEC_W-1:0] reduce_pairs(input logic [VEC_W-1:0] v, input int n_in);
    logic [VEC_W-1:0] r;
    int a;
    int b;
    r = '0;
    for (int j = 0; j < NUM_TERMS; j++) begin
      a = (2*j < NUM_TERMS) ? 2*j : 0;
      b = (2*j+1 < NUM_TERMS) ? 2*j+1 : 0;
      if (2*j+1 < n_in) begin
        r[j*SUM_W +: SUM_W] = v[a*SUM_W +: SUM_W] + v[b*SUM_W +: SUM_W];
      end else if (2*j < n_in) begin
        r[j*SUM_W +: SUM_W] = v[a*SUM_W +: SUM_W];
      end else begin
        r[j*SUM_W +: SUM_W] = '0;
      end
    end
    return r;
  endfunction

  logic               rst_meta_r;
  logic               rst_sync_r;
  logic               advance_s;
  logic               accept_s;
  logic [VEC_W-1:0]   lvl_r [LEVELS+1];
  logic [LEVELS:0]    vld_r;
  logic [LEVELS:0]    sgn_r;
  logic [LEVELS:0]    relu_r;
  logic [SHIFT_W-1:0] shf_r [LEVELS+1];

  logic [SUM_W-1:0]     tree_sum_s;
  logic [EXT_W-1:0]     ext_s;
  logic [EXT_W-1:0]     rnd_s;
  logic [EXT_W-1:0]     pre_s;
  logic [EXT_W-1:0]     shr_s;
  logic [OUT_WIDTH-1:0] clamp_s;
  logic                 sat_s;

  logic                 out_valid_r;
  logic [SUM_W-1:0]     out_sum_r;
  logic [OUT_WIDTH-1:0] out_data_r;
  logic                 out_sat_r;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= 1'b1;
    end else begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= rst_meta_r;
    end
  end

  assign advance_s    = !out_valid_r || bus.out_ready;
  assign bus.in_ready = advance_s && !rst_sync_r;
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Input capture plus the pairwise add levels; every stage moves in lockstep on advance.
  always_ff @(posedge clk or posedge rst_sync_r) begin
    if (rst_sync_r) begin
      for (int l = 0; l <= LEVELS; l++) begin
        lvl_r[l] <= '0;
        shf_r[l] <= '0;
      end
      vld_r  <= '0;
      sgn_r  <= '0;
      relu_r <= '0;
    end else if (advance_s) begin
      for (int k = 0; k < NUM_TERMS; k++) begin
        lvl_r[0][k*SUM_W +: SUM_W] <= extend_term(bus.in_data[k*PROD_W +: PROD_W], bus.in_signed);
      end
      vld_r[0]  <= accept_s;
      sgn_r[0]  <= bus.in_signed;
      shf_r[0]  <= bus.in_shift;
      relu_r[0] <= bus.in_relu;
      for (int l = 1; l <= LEVELS; l++) begin
        lvl_r[l]  <= reduce_pairs(lvl_r[l-1], terms_at(l-1));
        vld_r[l]  <= vld_r[l-1];
        sgn_r[l]  <= sgn_r[l-1];
        shf_r[l]  <= shf_r[l-1];
        relu_r[l] <= relu_r[l-1];
      end
    end
  end

  assign tree_sum_s = lvl_r[LEVELS][SUM_W-1:0];

  // Round-half-up shift at one guard bit above SUM_W, then ReLU and clamp.
  always_comb begin
    if (sgn_r[LEVELS]) begin
      ext_s = EXT_W'($signed(tree_sum_s));
    end else begin
      ext_s = EXT_W'(tree_sum_s);
    end
    if (shf_r[LEVELS] == '0) begin
      rnd_s = '0;
    end else begin
      rnd_s = EXT_W'(1'b1) << (shf_r[LEVELS] - SHIFT_W'(1));
    end
    pre_s = ext_s + rnd_s;
    if (sgn_r[LEVELS]) begin
      shr_s = EXT_W'($signed(pre_s) >>> shf_r[LEVELS]);
    end else begin
      shr_s = pre_s >> shf_r[LEVELS];
    end
    sat_s = 1'b0;
    if (sgn_r[LEVELS] && relu_r[LEVELS] && shr_s[EXT_W-1]) begin
      clamp_s = '0;
    end else if (sgn_r[LEVELS]) begin
      if ($signed(shr_s) > S_MAX) begin
        clamp_s = S_MAX[OUT_WIDTH-1:0];
        sat_s   = 1'b1;
      end else if ($signed(shr_s) < S_MIN) begin
        clamp_s = S_MIN[OUT_WIDTH-1:0];
        sat_s   = 1'b1;
      end else begin
        clamp_s = shr_s[OUT_WIDTH-1:0];
      end
    end else begin
      if (shr_s > U_MAX) begin
        clamp_s = U_MAX[OUT_WIDTH-1:0];
        sat_s   = 1'b1;
      end else begin
        clamp_s = shr_s[OUT_WIDTH-1:0];
      end
    end
  end

  // Output register; holds its contents while downstream stalls.
  always_ff @(posedge clk or posedge rst_sync_r) begin
    if (rst_sync_r) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= vld_r[LEVELS];
      out_sum_r   <= tree_sum_s;
      out_data_r  <= clamp_s;
      out_sat_r   <= sat_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;

  // Clear wins over a coincident saturated transfer; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst_sync_r) begin
    if (rst_sync_r) begin
      sat_count <= 16'h0000;
    end else if (sat_clear) begin
      sat_count <= 16'h0000;
    end else if (out_valid_r && bus.out_ready && out_sat_r && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end
  end
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe with 9 terms of 16-bit products: latency, modes,
// rounding, clamp, sat_count clear priority, stall stream ordering and mid-flight reset.
module tb_adder_tree_pipe;
  localparam int NT   = 9;
  localparam int PW   = 16;
  localparam int SUMW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clear;
  logic [15:0] sat_count;

  int          total = 0;
  int          bad   = 0;
  int          got_lat;
  logic [31:0] got_sum;
  logic [31:0] got_data;
  logic [31:0] got_sat;

  adder_tree_pipe_if #(.NUM_TERMS(NT), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(8), .SHIFT_W(4)) bus ();

  adder_tree_pipe #(.NUM_TERMS(NT), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(8), .SHIFT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NT*PW-1:0] rep(input logic [PW-1:0] v);
    logic [NT*PW-1:0] r;
    for (int k = 0; k < NT; k++) r[k*PW +: PW] = v;
    return r;
  endfunction

  // One beat with out_ready high; captures result and latency in edges from acceptance.
  task automatic send_beat(input logic [PW-1:0] term, input logic sgn, input logic [3:0] shf,
                           input logic relu, input logic clr_at_out);
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = rep(term);
    bus.in_signed = sgn;
    bus.in_shift  = shf;
    bus.in_relu   = relu;
    bus.out_ready = 1'b1;
    #1;
    check_val("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_lat  = lat;
    got_sum  = 32'(bus.out_sum);
    got_data = 32'(bus.out_data);
    got_sat  = 32'(bus.out_sat);
    if (clr_at_out) sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
  endtask

  initial begin
    int tx;
    int rx;
    int stale;
    rst           = 1'b1;
    sat_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.in_shift  = 4'd0;
    bus.in_relu   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check_val("rst_out_data",  32'(bus.out_data),  32'd0);
    check_val("rst_out_sat",   32'(bus.out_sat),   32'd0);
    check_val("rst_sat_count", 32'(sat_count),     32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("ready_after_rst", 32'(bus.in_ready), 32'd1);

    send_beat(16'h0001, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("u9_latency", 32'(got_lat), 32'd6);
    check_val("u9_sum",  got_sum,  32'd9);
    check_val("u9_data", got_data, 32'd9);
    check_val("u9_sat",  got_sat,  32'd0);

    send_beat(16'hFFFF, 1'b1, 4'd0, 1'b0, 1'b0);
    check_val("sneg_sum",  got_sum,  32'h000F_FFF7);
    check_val("sneg_data", got_data, 32'h0000_00F7);
    check_val("sneg_sat",  got_sat,  32'd0);
    send_beat(16'hFFFF, 1'b1, 4'd0, 1'b1, 1'b0);
    check_val("relu_sum",  got_sum,  32'h000F_FFF7);
    check_val("relu_data", got_data, 32'd0);
    check_val("relu_sat",  got_sat,  32'd0);

    send_beat(16'h00FF, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("usat_sum",  got_sum,  32'd2295);
    check_val("usat_data", got_data, 32'd255);
    check_val("usat_sat",  got_sat,  32'd1);
    check_val("sat_count_one", 32'(sat_count), 32'd1);
    send_beat(16'h00FF, 1'b0, 4'd0, 1'b0, 1'b1);
    check_val("sat_clear_prio", 32'(sat_count), 32'd0);

    send_beat(16'h0001, 1'b0, 4'd1, 1'b0, 1'b0);
    check_val("round_s1", got_data, 32'd5);
    send_beat(16'h0001, 1'b0, 4'd2, 1'b0, 1'b0);
    check_val("round_s2", got_data, 32'd2);
    send_beat(16'hFFFF, 1'b1, 4'd1, 1'b0, 1'b0);
    check_val("round_neg", got_data, 32'h0000_00FC);
    check_val("round_neg_sat", got_sat, 32'd0);

    send_beat(16'h00FF, 1'b1, 4'd0, 1'b0, 1'b0);
    check_val("spos_clamp", got_data, 32'h0000_007F);
    check_val("spos_sat",   got_sat,  32'd1);
    send_beat(16'hFF00, 1'b1, 4'd0, 1'b0, 1'b0);
    check_val("sneg_clamp_sum", got_sum,  32'h000F_F700);
    check_val("sneg_clamp",     got_data, 32'h0000_0080);
    check_val("sneg_clamp_sat", got_sat,  32'd1);
    check_val("sat_count_two", 32'(sat_count), 32'd2);

    // 20-beat stream with downstream stalled during cycles 8..17
    bus.in_signed = 1'b0;
    bus.in_shift  = 4'd0;
    bus.in_relu   = 1'b0;
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 80 && rx < 20; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 8 && cyc <= 17);
      bus.in_valid  = (tx < 20);
      bus.in_data   = rep(16'(tx + 1));
      #1;
      check_val("stream_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        check_val("stream_sum", 32'(bus.out_sum), 32'(9 * (rx + 1)));
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
    end
    check_val("stream_count", 32'(rx), 32'd20);
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Reset with a held result and three more beats in flight
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rep(16'(i + 50));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 12 && !bus.out_valid; i++) @(negedge clk);
    check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_sum",   32'(bus.out_sum),   32'd0);
    check_val("mid_rst_count", 32'(sat_count),     32'd0);
    repeat (2) @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_val("no_stale_out", 32'(stale), 32'd0);
    send_beat(16'h0002, 1'b0, 4'd0, 1'b0, 1'b0);
    check_val("post_rst_latency", 32'(got_lat), 32'd6);
    check_val("post_rst_sum",     got_sum,      32'd18);
    check_val("post_rst_data",    got_data,     32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
